// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - binary32 format constants and rounding-mode encodings
package fpu_pkg;

  localparam int F32_BIAS   = 127;
  localparam int F32_MANT_W = 23;
  localparam int F32_EXP_W  = 8;

  localparam logic RM_RNE = 1'b0;
  localparam logic RM_RTZ = 1'b1;

endpackage

// File: rtl/itof_pipe_lzc.sv
// rtl/itof_pipe_lzc.sv - combinational priority leading-zero counter
module lzc #(
  parameter int W = 32
) (
  input  logic [W-1:0]         x,
  output logic [$clog2(W)-1:0] cnt,
  output logic                 zero
);

  localparam int CW = $clog2(W);

  // Scan upward so the highest set bit is the last one to assign.
  always_comb begin
    cnt  = '0;
    zero = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (x[i]) begin
        cnt  = CW'(W - 1 - i);
        zero = 1'b0;
      end
    end
  end

endmodule

// File: rtl/itof_pipe.sv
// rtl/itof_pipe.sv - three-stage integer to binary32 converter with global stall
module itof_pipe
  import fpu_pkg::*;
#(
  parameter int INT_W = 32,
  parameter int LZC_W = $clog2(INT_W)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INT_W-1:0] in_data,
  input  logic             in_signed,
  input  logic             in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_inexact
);

  localparam int FW = INT_W - 1 + F32_MANT_W + 1;
  localparam logic [F32_EXP_W-1:0] EXP_TOP = F32_EXP_W'(F32_BIAS + INT_W - 1);

  logic w_advance;
  assign w_advance = ~out_valid | out_ready;
  assign in_ready  = w_advance;

  // Stage 1: sign and magnitude; negating the most negative value wraps onto 2^(INT_W-1).
  logic             w_sign;
  logic [INT_W-1:0] w_mag;
  assign w_sign = in_signed & in_data[INT_W-1];
  assign w_mag  = w_sign ? (~in_data + INT_W'(1)) : in_data;

  logic             r1_valid, r1_sign, r1_rm;
  logic [INT_W-1:0] r1_mag;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r1_valid <= 1'b0;
      r1_sign  <= 1'b0;
      r1_rm    <= RM_RNE;
      r1_mag   <= '0;
    end else if (w_advance) begin
      r1_valid <= in_valid;
      r1_sign  <= w_sign;
      r1_rm    <= in_rm;
      r1_mag   <= w_mag;
    end
  end

  // Stage 2: normalise so the leading one drops off the top; pad below for narrow operands.
  logic [LZC_W-1:0] w_lzc;
  logic             w_zero;
  logic [INT_W-2:0] w_norm;
  logic [FW-1:0]    w_ext;

  lzc #(.W(INT_W)) u_lzc (
    .x    (r1_mag),
    .cnt  (w_lzc),
    .zero (w_zero)
  );

  assign w_norm = (INT_W-1)'(r1_mag << w_lzc);
  assign w_ext  = {w_norm, (F32_MANT_W+1)'(0)};

  logic                  r2_valid, r2_sign, r2_rm, r2_zero, r2_guard, r2_sticky;
  logic [LZC_W-1:0]      r2_lzc;
  logic [F32_MANT_W-1:0] r2_mant;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r2_valid  <= 1'b0;
      r2_sign   <= 1'b0;
      r2_rm     <= RM_RNE;
      r2_zero   <= 1'b1;
      r2_lzc    <= '0;
      r2_mant   <= '0;
      r2_guard  <= 1'b0;
      r2_sticky <= 1'b0;
    end else if (w_advance) begin
      r2_valid  <= r1_valid;
      r2_sign   <= r1_sign;
      r2_rm     <= r1_rm;
      r2_zero   <= w_zero;
      r2_lzc    <= w_lzc;
      r2_mant   <= w_ext[FW-1 -: F32_MANT_W];
      r2_guard  <= w_ext[INT_W-1];
      r2_sticky <= |w_ext[INT_W-2:0];
    end
  end

  // Stage 3: round, fold any mantissa carry into the exponent, pack.
  logic                  w_inc, w_carry;
  logic [F32_MANT_W:0]   w_sum;
  logic [F32_EXP_W-1:0]  w_exp;
  logic [31:0]           w_res;

  assign w_inc   = (r2_rm == RM_RNE) & r2_guard & (r2_sticky | r2_mant[0]);
  assign w_sum   = {1'b0, r2_mant} + (F32_MANT_W+1)'(w_inc);
  assign w_carry = w_sum[F32_MANT_W];
  assign w_exp   = EXP_TOP - F32_EXP_W'(r2_lzc) + F32_EXP_W'(w_carry);
  assign w_res   = r2_zero ? 32'h0 : {r2_sign, w_exp, w_sum[F32_MANT_W-1:0]};

  logic        r3_valid, r3_inexact;
  logic [31:0] r3_data;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r3_valid   <= 1'b0;
      r3_data    <= '0;
      r3_inexact <= 1'b0;
    end else if (w_advance) begin
      r3_valid   <= r2_valid;
      r3_data    <= w_res;
      r3_inexact <= ~r2_zero & (r2_guard | r2_sticky);
    end
  end

  assign out_valid   = r3_valid;
  assign out_data    = r3_data;
  assign out_inexact = r3_inexact;

endmodule

// File: tb/tb_itof_pipe.sv
// tb/tb_itof_pipe.sv - directed and model-based bench for itof_pipe at 16, 32 and 64 bits
module tb_itof_pipe;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        v16, v32, v64, r16, r32, r64, s16, s32, s64, m16, m32, m64;
  logic        ir16, ir32, ir64, ov16, ov32, ov64, ox16, ox32, ox64;
  logic [15:0] d16;
  logic [31:0] d32, o16, o32, o64;
  logic [63:0] d64;

  itof_pipe #(.INT_W(16)) u16 (
    .clk(clk), .rstn(rstn), .in_valid(v16), .in_ready(ir16), .in_data(d16),
    .in_signed(s16), .in_rm(m16), .out_valid(ov16), .out_ready(r16),
    .out_data(o16), .out_inexact(ox16)
  );
  itof_pipe #(.INT_W(32)) u32 (
    .clk(clk), .rstn(rstn), .in_valid(v32), .in_ready(ir32), .in_data(d32),
    .in_signed(s32), .in_rm(m32), .out_valid(ov32), .out_ready(r32),
    .out_data(o32), .out_inexact(ox32)
  );
  itof_pipe #(.INT_W(64)) u64 (
    .clk(clk), .rstn(rstn), .in_valid(v64), .in_ready(ir64), .in_data(d64),
    .in_signed(s64), .in_rm(m64), .out_valid(ov64), .out_ready(r64),
    .out_data(o64), .out_inexact(ox64)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int w, input logic v, input logic [63:0] d, input logic s, input logic rm);
    case (w)
      16:      begin v16 = v; d16 = d[15:0]; s16 = s; m16 = rm; end
      32:      begin v32 = v; d32 = d[31:0]; s32 = s; m32 = rm; end
      default: begin v64 = v; d64 = d;       s64 = s; m64 = rm; end
    endcase
  endtask

  function automatic logic ov(input int w);
    return (w == 16) ? ov16 : (w == 32) ? ov32 : ov64;
  endfunction
  function automatic logic [31:0] od(input int w);
    return (w == 16) ? o16 : (w == 32) ? o32 : o64;
  endfunction
  function automatic logic ox(input int w);
    return (w == 16) ? ox16 : (w == 32) ? ox32 : ox64;
  endfunction

  // Reference: truncate to 24 significant bits, then round by comparing the remainder to one half.
  function automatic logic [32:0] ref_cvt(input int w, input logic [63:0] d, input logic s, input logic rm);
    logic [63:0] mask, x, mag, sig, rem, half;
    logic        neg, inx;
    logic [7:0]  e;
    int          p;
    mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    x    = d & mask;
    neg  = s & x[w-1];
    mag  = neg ? ((~x + 64'd1) & mask) : x;
    if (mag == 64'd0) return 33'd0;
    p = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) p = i;
    inx = 1'b0;
    if (p <= 23) begin
      sig = mag << (23 - p);
    end else begin
      sig  = mag >> (p - 23);
      rem  = mag & ((64'd1 << (p - 23)) - 64'd1);
      half = 64'd1 << (p - 24);
      inx  = (rem != 64'd0);
      if (!rm && (rem > half || (rem == half && sig[0]))) sig = sig + 64'd1;
    end
    e = 8'(127 + p);
    if (sig[24]) begin
      sig = sig >> 1;
      e   = e + 8'd1;
    end
    return {inx, neg, e, sig[22:0]};
  endfunction

  task automatic runw(input int w, input logic [63:0] d, input logic s, input logic rm,
                      input logic [31:0] ed, input logic ei, input string tag);
    int n;
    drv(w, 1'b1, d, s, rm);
    @(posedge clk); #1;
    drv(w, 1'b0, 64'd0, 1'b0, 1'b0);
    n = 1;
    while (!ov(w) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'd3);
    chk({tag, "_data"}, 64'(od(w)), 64'(ed));
    chk({tag, "_inx"}, 64'(ox(w)), 64'(ei));
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_in  [8] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'hFFFFFFFE};
  logic [31:0] bp_exp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                              32'h40A00000, 32'h40C00000, 32'h40E00000, 32'hC0000000};

  initial begin
    int          idx, got, cyc;
    logic        acc_in, stalled;
    logic [31:0] prev;
    logic [63:0] rd;
    logic [32:0] rr;
    logic        rs, rm;
    int          rw;

    rstn = 1'b0;
    drv(16, 1'b0, 64'd0, 1'b0, 1'b0);
    drv(32, 1'b0, 64'd0, 1'b0, 1'b0);
    drv(64, 1'b0, 64'd0, 1'b0, 1'b0);
    r16 = 1'b1; r32 = 1'b1; r64 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ovalid", 64'({ov16, ov32, ov64}), 64'd0);
    chk("rst_iready", 64'({ir16, ir32, ir64}), 64'h7);
    chk("rst_data", 64'(o32), 64'd0);
    chk("rst_inx", 64'(ox32), 64'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    runw(32, 64'hFFFFFFFF, 1'b1, 1'b0, 32'hBF800000, 1'b0, "neg1");
    runw(32, 64'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b0, "zero");
    runw(32, 64'h80000000, 1'b1, 1'b0, 32'hCF000000, 1'b0, "smin");
    runw(32, 64'h80000000, 1'b0, 1'b0, 32'h4F000000, 1'b0, "u2p31");
    runw(32, 64'h00000001, 1'b0, 1'b0, 32'h3F800000, 1'b0, "one");
    runw(32, 64'h7FFFFFFF, 1'b1, 1'b0, 32'h4F000000, 1'b1, "smax_rne");
    runw(32, 64'h7FFFFFFF, 1'b1, 1'b1, 32'h4EFFFFFF, 1'b1, "smax_rtz");
    runw(32, 64'hFFFFFFFF, 1'b0, 1'b0, 32'h4F800000, 1'b1, "umax_rne");
    runw(32, 64'hFFFFFFFF, 1'b0, 1'b1, 32'h4F7FFFFF, 1'b1, "umax_rtz");
    runw(32, 64'h01000001, 1'b0, 1'b0, 32'h4B800000, 1'b1, "tie_even");
    runw(32, 64'h01000003, 1'b0, 1'b0, 32'h4B800002, 1'b1, "tie_up");
    runw(32, 64'h00FFFFFF, 1'b0, 1'b0, 32'h4B7FFFFF, 1'b0, "exact24");

    // Back-pressure: random out_ready, in-order delivery, data frozen while stalled.
    idx = 0; got = 0; cyc = 0; stalled = 1'b0; prev = '0;
    drv(32, 1'b1, 64'(bp_in[0]), 1'b1, 1'b0);
    while (got < 8 && cyc < 300) begin
      r32 = 1'($urandom_range(0, 1));
      #1;
      if (stalled) chk("bp_stable", 64'(o32), 64'(prev));
      acc_in = v32 & ir32;
      if (ov32 && r32) begin
        chk($sformatf("bp_out%0d", got), 64'(o32), 64'(bp_exp[got]));
        got++;
      end
      stalled = ov32 & ~r32;
      prev    = o32;
      @(posedge clk); #1;
      if (acc_in) begin
        idx++;
        if (idx < 8) d32 = bp_in[idx];
        else v32 = 1'b0;
      end
      cyc++;
    end
    chk("bp_count", 64'(got), 64'd8);
    r32 = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_nodup", 64'(ov32), 64'd0);
    end

    // Reset with three operands held in the pipe.
    r32 = 1'b0;
    drv(32, 1'b1, 64'd9, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    drv(32, 1'b0, 64'd0, 1'b0, 1'b0);
    chk("mid_full", 64'(ov32), 64'd1);
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    r32  = 1'b1;
    chk("mid_ovalid", 64'(ov32), 64'd0);
    chk("mid_iready", 64'(ir32), 64'd1);
    chk("mid_data", 64'(o32), 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("mid_flushed", 64'(ov32), 64'd0);
    end
    runw(32, 64'd10, 1'b0, 1'b0, 32'h41200000, 1'b0, "post_rst");

    runw(16, 64'h8000, 1'b1, 1'b0, 32'hC7000000, 1'b0, "w16_smin");
    runw(16, 64'hFFFF, 1'b0, 1'b1, 32'h477FFF00, 1'b0, "w16_umax");
    runw(64, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 32'h5F800000, 1'b1, "w64_umax");
    runw(64, 64'h8000000000000000, 1'b1, 1'b0, 32'hDF000000, 1'b0, "w64_smin");

    for (int i = 0; i < 30; i++) begin
      rw = (i % 3 == 0) ? 16 : (i % 3 == 1) ? 32 : 64;
      rd = {$urandom, $urandom} >> $urandom_range(0, 60);
      rs = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      rr = ref_cvt(rw, rd, rs, rm);
      runw(rw, rd, rs, rm, rr[31:0], rr[32], $sformatf("rnd%0d_w%0d", i, rw));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
